fork_nav_ctrl: RTL

FORK_NAV_CTRL -- requirements
Module: fork_nav_ctrl

---
 rtl/fork_nav_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fork_nav_ctrl.sv
// fork_nav_ctrl: navigation sequencer for a line-following car at track forks.
// The car drives forward until a fork is seen for DEBOUNCE_CYC cycles. It then
// stops for STOP_CYC cycles, turns for TURN_CYC cycles and drives forward again.
// The fork is counted once detect_fork has stayed low for DEBOUNCE_CYC cycles.
// Optional feature macro: FORK_DIR_INPUT_EN
//   undefined: the turn direction alternates, starting with left after reset.
//   defined:   dir_sel picks the direction (0 = left, 1 = right). It is
//              sampled when debouncing completes.
// All outputs are registered. They are computed from the next state, so they
// change on the same edge as the state.
module fork_nav_ctrl #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int STOP_CYC     = 8,
  parameter int TURN_CYC     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       detect_fork,
`ifdef FORK_DIR_INPUT_EN
  input  logic       dir_sel,
`endif
  output logic [1:0] move_cmd,
  output logic       busy,
  output logic [7:0] fork_count
);

  // One shared counter covers the longest of the three timed phases.
  localparam int CNT_MAX_A = (DEBOUNCE_CYC > STOP_CYC) ? DEBOUNCE_CYC : STOP_CYC;
  localparam int CNT_MAX   = (CNT_MAX_A > TURN_CYC) ? CNT_MAX_A : TURN_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] STOP_LIM = CNT_W'(STOP_CYC);
  localparam logic [CNT_W-1:0] TURN_LIM = CNT_W'(TURN_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DEBOUNCE = 3'd1;
  localparam logic [2:0] STOP     = 3'd2;
  localparam logic [2:0] TURN     = 3'd3;
  localparam logic [2:0] EXIT     = 3'd4;

  localparam logic [1:0] CMD_STOP  = 2'b00;
  localparam logic [1:0] CMD_FWD   = 2'b01;
  localparam logic [1:0] CMD_LEFT  = 2'b10;
  localparam logic [1:0] CMD_RIGHT = 2'b11;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             turn_right, turn_right_nxt;
  logic [7:0]       count_nxt;
  logic [1:0]       move_nxt;
  logic             pick_right;

`ifdef FORK_DIR_INPUT_EN
  assign pick_right = dir_sel;
`else
  logic toggle, toggle_nxt;
  assign pick_right = toggle;
`endif

  assign cnt_inc = cnt + CNT_ONE;

  // Next-state, counter, direction and fork-count logic for the fork sequence.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    turn_right_nxt = turn_right;
    count_nxt      = fork_count;
`ifndef FORK_DIR_INPUT_EN
    toggle_nxt     = toggle;
`endif
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (detect_fork) begin
            state_nxt = DEBOUNCE;
            cnt_nxt   = CNT_ONE;
          end
        end
        DEBOUNCE: begin
          if (!detect_fork) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt_inc >= DEB_LIM) begin
            state_nxt      = STOP;
            cnt_nxt        = CNT_ONE;
            turn_right_nxt = pick_right;
`ifndef FORK_DIR_INPUT_EN
            toggle_nxt     = ~toggle;
`endif
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        STOP: begin
          if (cnt >= STOP_LIM) begin
            state_nxt = TURN;
            cnt_nxt   = CNT_ONE;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        TURN: begin
          if (cnt >= TURN_LIM) begin
            state_nxt = EXIT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        EXIT: begin
          if (detect_fork) begin
            cnt_nxt = '0;
          end else if (cnt_inc >= DEB_LIM) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            if (fork_count != 8'hFF) begin
              count_nxt = fork_count + 8'd1;
            end
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Motion command that belongs to the state being entered on this edge.
  always_comb begin
    move_nxt = CMD_FWD;
    case (state_nxt)
      IDLE:    move_nxt = enable ? CMD_FWD : CMD_STOP;
      STOP:    move_nxt = CMD_STOP;
      TURN:    move_nxt = turn_right_nxt ? CMD_RIGHT : CMD_LEFT;
      default: move_nxt = CMD_FWD;
    endcase
  end

  // State, counter and registered outputs update together on each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      turn_right <= 1'b0;
      move_cmd   <= CMD_STOP;
      busy       <= 1'b0;
      fork_count <= 8'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      turn_right <= turn_right_nxt;
      move_cmd   <= move_nxt;
      busy       <= (state_nxt != IDLE);
      fork_count <= count_nxt;
    end
  end

`ifndef FORK_DIR_INPUT_EN
  // Alternating-direction bit. It survives enable drops and clears only on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle <= 1'b0;
    end else begin
      toggle <= toggle_nxt;
    end
  end
`endif

endmodule
